mant_seq_mult: RTL and testbench



---
 rtl/mant_seq_mult_pkg.sv | 13 +
 rtl/mant_seq_mult_counter_4_bits_en.sv | 29 ++
 rtl/mant_seq_mult.sv | 129 ++++++++++++
 tb/tb_mant_seq_mult.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mant_seq_mult_pkg.sv
// Shared constants and FSM state encoding for the sequential mantissa multiplier.
package mant_seq_mult_pkg;

   localparam int MANT_W = 11;
   localparam int ITER_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mant_seq_mult_counter_4_bits_en.sv
// Iteration counter: up-counter with synchronous clear and count enable.
module counter_4_bits_en
   import mant_seq_mult_pkg::*;
(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic              en,
   output logic [ITER_W-1:0] count
);

   logic [ITER_W-1:0] count_r;

   // Count register: clear has priority over enable.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_r <= {ITER_W{1'b0}};
      end else if (clear) begin
         count_r <= {ITER_W{1'b0}};
      end else if (en) begin
         count_r <= count_r + ITER_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/mant_seq_mult.sv
// Shift-add mantissa multiplier: one multiplier bit retired per clock, product
// presented with a one-cycle done pulse after WIDTH iterations.
module mant_seq_mult
   import mant_seq_mult_pkg::*;
#(
   parameter int WIDTH = MANT_W
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   state_t              state_r;
   state_t              state_next_s;
   logic                accept_s;
   logic                run_s;
   logic                last_s;
   logic [ITER_W-1:0]   cnt_s;
   logic [WIDTH-1:0]    mcand_r;
   logic [WIDTH-1:0]    mplier_r;
   logic [WIDTH:0]      acc_r;
   logic [WIDTH:0]      sum_s;
   logic                busy_r;
   logic                done_r;
   logic [2*WIDTH-1:0]  product_r;

   counter_4_bits_en u_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (accept_s),
      .en    (run_s),
      .count (cnt_s)
   );

   assign run_s  = (state_r == RUN);
   assign last_s = run_s && (cnt_s == ITER_W'(WIDTH - 1));

   // Partial-product adder; acc is one bit wider to keep the carry.
   always_comb begin
      sum_s = {(WIDTH + 1){1'b0}};
      if (mplier_r[0]) begin
         sum_s = acc_r + {1'b0, mcand_r};
      end else begin
         sum_s = acc_r;
      end
   end

   // Next-state logic; start is only honoured in IDLE.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = RUN;
               accept_s     = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Operand load on accept, then {acc, mplier} shifts right once per iteration.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mcand_r  <= {WIDTH{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         acc_r    <= {(WIDTH + 1){1'b0}};
      end else if (accept_s) begin
         mcand_r  <= a;
         mplier_r <= b;
         acc_r    <= {(WIDTH + 1){1'b0}};
      end else if (run_s) begin
         mcand_r  <= mcand_r;
         mplier_r <= {sum_s[0], mplier_r[WIDTH-1:1]};
         acc_r    <= {1'b0, sum_s[WIDTH:1]};
      end else begin
         mcand_r  <= mcand_r;
         mplier_r <= mplier_r;
         acc_r    <= acc_r;
      end
   end

   // Registered status and product; product is captured from the final shift.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= {(2 * WIDTH){1'b0}};
      end else begin
         busy_r <= (state_next_s != IDLE);
         done_r <= (state_next_s == DONE);
         if (last_s) begin
            product_r <= {sum_s, mplier_r[WIDTH-1:1]};
         end else begin
            product_r <= product_r;
         end
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign product = product_r;

endmodule

// File: tb/tb_mant_seq_mult.sv
// Directed bench for mant_seq_mult: cycle-level reference model plus literal product checks.
module tb_mant_seq_mult;

   localparam int W = 11;

   logic           clk = 1'b0;
   logic           n_rst = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int total = 0;
   int passed = 0;
   logic mon_en = 1'b0;

   mant_seq_mult #(.WIDTH(W)) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: edges elapsed since acceptance, product by plain multiplication.
   int             m_since = -1;
   logic           m_busy = 1'b0;
   logic           m_done = 1'b0;
   logic [2*W-1:0] m_prod = '0;
   logic [2*W-1:0] m_pa = '0;
   logic [2*W-1:0] m_pb = '0;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_since <= -1;
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_prod  <= '0;
      end else if (m_since < 0) begin
         if (start) begin
            m_since <= 0;
            m_pa    <= {{W{1'b0}}, a};
            m_pb    <= {{W{1'b0}}, b};
            m_busy  <= 1'b1;
         end
      end else if (m_since == W - 1) begin
         m_since <= W;
         m_done  <= 1'b1;
         m_prod  <= m_pa * m_pb;
      end else if (m_since == W) begin
         m_since <= -1;
         m_done  <= 1'b0;
         m_busy  <= 1'b0;
      end else begin
         m_since <= m_since + 1;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("cyc_busy", busy, m_busy);
         check("cyc_done", done, m_done);
         check("cyc_product", product, m_prod);
      end
   end

   task automatic do_mult(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [2*W-1:0] exp_p);
      int done_at, done_cnt, busy_cnt;
      logic [2*W-1:0] got;
      done_at = -1; done_cnt = 0; busy_cnt = 0; got = '0;
      a = aa; b = bb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~aa; b = ~bb;
      for (int i = 1; i <= 40; i++) begin
         if (busy) busy_cnt++;
         if (done) begin done_cnt++; done_at = i; got = product; end
         if (!busy) break;
         @(negedge clk);
      end
      check("done_latency", done_at, W + 1);
      check("done_pulses", done_cnt, 1);
      check("busy_cycles", busy_cnt, W + 1);
      check("product", got, exp_p);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rise2, dcnt, nd;
      logic prev_busy;
      logic [2*W-1:0] got;

      repeat (3) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_product", product, 22'h0);
      n_rst = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      do_mult(11'h400, 11'h400, 22'h100000);
      do_mult(11'h7FF, 11'h7FF, 22'h3FF001);
      do_mult(11'h5A5, 11'h000, 22'h000000);

      // Start held high; operands change mid-RUN.
      rise2 = -1; dcnt = 0; got = '0; prev_busy = busy;
      a = 11'h401; b = 11'h403; start = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 4) begin a = 11'h123; b = 11'h045; end
         if (busy && !prev_busy && i > 1 && rise2 < 0) begin
            rise2 = i;
            start = 1'b0;
         end
         if (done && rise2 < 0) begin dcnt++; got = product; end
         prev_busy = busy;
      end
      check("reaccept_gap", rise2 - 1, 13);
      check("held_start_pulses", dcnt, 1);
      check("held_start_product", got, 22'h101003);
      check("second_product", product, 22'h004E6F);

      // Reset at iteration 5.
      a = 11'h3FF; b = 11'h3FF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      n_rst = 1'b0;
      #1;
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_done", done, 1'b0);
      check("rst_mid_product", product, 22'h0);
      @(negedge clk);
      n_rst = 1'b1;
      nd = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("rst_no_done", nd, 0);

      do_mult(11'h600, 11'h500, 22'h1E0000);

      repeat (20) begin
         @(negedge clk);
         check("hold_product", product, 22'h1E0000);
         check("hold_done", done, 1'b0);
      end

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
